// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, FSM states and
// the EXEC-cycle strobe decode.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LDR  = 4'hA;
  localparam logic [3:0] OP_STR  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_SYS  = 4'hF;

  localparam logic [7:0] RET_INSN = 8'hF0;

  typedef enum logic [2:0] {IDLE, FETCH, FETCH_OP, EXEC, HALT} state_t;

  typedef struct packed {
    logic reg_we;
    logic mem_we;
    logic use_imm;
    logic mem_to_reg;
  } ctl_t;

  function automatic logic has_operand(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_CALL);
  endfunction

  // ALU ops, LDI and LDR all write back; only STR touches data memory.
  function automatic ctl_t decode(input logic [3:0] op);
    ctl_t c;
    c            = '0;
    c.reg_we     = (op <= OP_LDR);
    c.mem_we     = (op == OP_STR);
    c.use_imm    = (op == OP_LDI);
    c.mem_to_reg = (op == OP_LDR);
    return c;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Instruction-fetch handshake between the sequencer (master) and instruction
// memory (slave); memory may stretch a request with any number of wait cycles.
interface ctrl_sequencer_if #(parameter int ADDR_W = 8);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [7:0]        imem_data;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_data);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/ctrl_sequencer_ret_stack.sv
// Return-address LIFO. Push into a full stack or pop from an empty one is
// ignored here; the sequencer turns those cases into a fault.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int SP_W = $clog2(DEPTH + 1);

  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] top;
  logic [W-1:0]    mem [2**SP_W];

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);
  assign top   = sp - 1'b1;
  assign dout  = mem[top];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 sp <= '0;
    else if (push && !full)     sp <= sp + 1'b1;
    else if (pop && !empty)     sp <= sp - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[sp] <= din;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns the PC, the fetch handshake,
// the return stack and HALT; emits one-cycle datapath strobes in EXEC.
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 8,
  parameter int REG_SEL_W   = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ctrl_sequencer_if.master     imem,
  input  logic [DATA_W-1:0]    src_data,
  output logic [3:0]           alu_op,
  output logic [REG_SEL_W-1:0] dest_reg,
  output logic [REG_SEL_W-1:0] source_reg,
  output logic [DATA_W-1:0]    immediate,
  output logic                 use_immediate,
  output logic                 reg_we,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_to_reg,
  output logic [ADDR_W-1:0]    pc,
  output logic                 halted,
  output logic                 stack_err
);
  state_t            state;
  logic [7:0]        ir, opnd;
  ctl_t              ctl;
  logic              req;
  logic              is_call, is_ret;
  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_dout;

  assign is_call  = (ir[7:4] == OP_CALL);
  assign is_ret   = (ir == RET_INSN);
  assign stk_push = (state == EXEC) && is_call && !stk_full;
  assign stk_pop  = (state == EXEC) && is_ret && !stk_empty;

  ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Strobes are computed one state ahead so they are registered and appear
  // only for the single EXEC cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      opnd      <= '0;
      ctl       <= '0;
      req       <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req   <= 1'b1;
        end
        FETCH: if (imem.imem_ack) begin
          ir <= imem.imem_data;
          pc <= pc + 1'b1;
          if (has_operand(imem.imem_data[7:4])) begin
            state <= FETCH_OP;
          end else begin
            state <= EXEC;
            req   <= 1'b0;
            ctl   <= decode(imem.imem_data[7:4]);
          end
        end
        FETCH_OP: if (imem.imem_ack) begin
          opnd  <= imem.imem_data;
          pc    <= pc + 1'b1;
          state <= EXEC;
          req   <= 1'b0;
          ctl   <= decode(ir[7:4]);
        end
        EXEC: begin
          ctl   <= '0;
          state <= FETCH;
          req   <= 1'b1;
          case (ir[7:4])
            OP_JMP: pc <= opnd[ADDR_W-1:0];
            OP_JZ:  if (src_data == '0) pc <= opnd[ADDR_W-1:0];
            OP_CALL: begin
              if (stk_full) begin
                state     <= HALT;
                req       <= 1'b0;
                halted    <= 1'b1;
                stack_err <= 1'b1;
              end else begin
                pc <= opnd[ADDR_W-1:0];
              end
            end
            OP_SYS: begin
              if (is_ret && !stk_empty) begin
                pc <= stk_dout;
              end else begin
                state  <= HALT;
                req    <= 1'b0;
                halted <= 1'b1;
                if (is_ret) stack_err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  assign alu_op        = ir[7:4];
  assign dest_reg      = REG_SEL_W'(ir[3:2]);
  assign source_reg    = REG_SEL_W'(ir[1:0]);
  assign immediate     = opnd[DATA_W-1:0];
  assign mem_addr      = opnd[ADDR_W-1:0];
  assign reg_we        = ctl.reg_we;
  assign mem_we        = ctl.mem_we;
  assign use_immediate = ctl.use_imm;
  assign mem_to_reg    = ctl.mem_to_reg;

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised multi-cycle fetch/decode/execute sequencer for the small CPU family; next generation of the single-cycle decode block.
- Owns the PC, a fetch handshake to instruction memory with variable latency, an internal return stack and the HALT state.
- Issues one-cycle datapath control strobes (register file, ALU, data memory).
- Uses the same 8-bit instruction encoding: opcode in bits [7:4], dest in [3:2], source in [1:0]; operand is a second byte.

Parameters:
- DATA_W, 4, datapath width; immediate = operand byte [DATA_W-1:0]; legal range 1..8.
- ADDR_W, 8, PC, jump and data-memory address width; taken from operand byte [ADDR_W-1:0]; legal range 1..8.
- REG_SEL_W, 2, register selector width; fields are zero-extended from the 2-bit instruction fields.
- STACK_DEPTH, 4, return-stack entries; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address; equals pc
- imem_ack  in  1  fetch data valid this cycle
- imem_data  in  8  fetched byte
- src_data  in  DATA_W  register-file read of source_reg (used by JZ)
- alu_op  out  4  opcode of the latched instruction
- dest_reg  out  REG_SEL_W  destination register select
- source_reg  out  REG_SEL_W  source register select
- immediate  out  DATA_W  LDI value
- use_immediate  out  1  ALU takes immediate
- reg_we  out  1  register write strobe
- mem_we  out  1  data-memory write strobe
- mem_addr  out  ADDR_W  LDR/STR address
- mem_to_reg  out  1  write-back selects memory data
- pc  out  ADDR_W  current PC
- halted  out  1  in HALT state
- stack_err  out  1  sticky stack overflow/underflow flag

Behaviour:
- While reset is low:
  - state=IDLE; pc=0; stack pointer=0; ir=0; opnd=0; stack_err=0.
  - All strobes (imem_req, reg_we, mem_we, use_immediate, mem_to_reg) are 0; halted=0.
  - A reset asserted mid-operation aborts immediately. No strobe may be high in the cycle reset is asserted.
- States and transitions:
  - IDLE -> FETCH unconditionally, one cycle after reset is released.
  - FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ack. On ack: ir<=imem_data, pc<=pc+1. Opcode 1001..1110 -> FETCH_OP; otherwise -> EXEC.
  - FETCH_OP: same handshake. On ack: opnd<=imem_data, pc<=pc+1, -> EXEC.
  - EXEC: lasts exactly one cycle. Strobes are asserted only in EXEC, decoded from ir/opnd. Next state is FETCH, or HALT as defined below.
  - HALT: halted=1, no request. Left only by reset.
- imem_ack is ignored when imem_req=0.
- PC increment wraps modulo 2^ADDR_W.
- Latency with zero-wait memory (ack in the request cycle):
  - single-byte instruction: 2 cycles;
  - two-byte instruction: 3 cycles.
- EXEC decode:
  - Opcodes 0000-1000: reg_we=1; alu_op=opcode.
  - LDI (1001): reg_we=1, use_immediate=1, immediate=opnd[DATA_W-1:0].
  - LDR (1010): reg_we=1, mem_to_reg=1, mem_addr=opnd[ADDR_W-1:0].
  - STR (1011): mem_we=1, mem_addr as for LDR, reg_we=0.
  - JMP (1100): pc<=opnd[ADDR_W-1:0].
  - JZ (1101): pc<=opnd[ADDR_W-1:0] only if src_data==0; otherwise pc is unchanged (already advanced past the operand).
  - CALL (1110): push current pc (the return address, already past the operand); then pc<=opnd[ADDR_W-1:0].
  - 1111_0000 = RET: pop into pc.
  - Any other 1111_xxxx = HALT: next state HALT.
- Outside EXEC:
  - alu_op, dest_reg and source_reg hold the ir fields.
  - immediate and mem_addr hold the opnd fields.
  - All write strobes are 0.
- Stack boundaries:
  - CALL with the stack full: no push, no jump, stack_err<=1, -> HALT.
  - RET with the stack empty: same response.
  - Exactly STACK_DEPTH nested CALLs succeed.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_ADD..OP_SYS);
  - the state enum (IDLE, FETCH, FETCH_OP, EXEC, HALT);
  - the RET encoding 8'hF0.
- One sub-module: ret_stack (parametrised LIFO).
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty.
  - Reset is asynchronous, active-low.

Test Plan:
- Reset and fetch start: release reset; imem_ack tied 1 returning 8'h00 (ADD) -> imem_req=0 for one cycle (IDLE); EXEC at cycle 2 with reg_we=1, alu_op=0; pc=1.
- Wait states: memory holds ack low for 3 cycles on LDI 8'h94, 8'h07 -> imem_addr stable while waiting; EXEC shows reg_we=1, use_immediate=1, immediate=4'h7, dest_reg=1; pc=2.
- JZ, both outcomes: 8'hD1, 8'h20 at pc=5:
  - with src_data=0 -> pc=0x20;
  - with src_data=3 -> pc=7.
- CALL/RET with overflow: CALL 0x40 placed at pc=0x10 -> pc=0x40; RET -> pc=0x12. Nesting 5 CALLs with STACK_DEPTH=4 -> 5th raises stack_err=1 and halted=1.
- HALT and mid-operation reset: 8'hF3 -> halted=1 and no further imem_req. Reset asserted mid-FETCH_OP -> strobes 0 in the same cycle; restarts from pc=0.
- Parameter sweep: DATA_W=8, ADDR_W=6; LDI operand 8'hA5 -> immediate=8'hA5. JMP operand 8'hFF -> pc=6'h3F; the next increment wraps pc to 0.
